// File: rtl/sd_read_arbiter_if.sv
// Bus bundle between the SD read arbiter and its environment: two requester
// channels plus the shared SD read port and status outputs.
interface sd_read_arbiter_if;
    logic       req0_read_req;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req1_read_req;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       sd_read_req;
    logic       sd_data_valid;
    logic [7:0] sd_data;
    logic [1:0] grant;
    logic       timeout_err;
    logic       err_src;

    // Environment side: requesters and the SD interface.
    modport master (
        output req0_read_req, req1_read_req, sd_data_valid, sd_data,
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  sd_read_req, grant, timeout_err, err_src
    );

    // Arbiter side.
    modport slave (
        input  req0_read_req, req1_read_req, sd_data_valid, sd_data,
        output req0_valid, req0_data, req1_valid, req1_data,
        output sd_read_req, grant, timeout_err, err_src
    );
endinterface

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing the single SD-card read port between the audio
// sample reader (requester 0) and the coefficient loader (requester 1).
// One transaction at a time; a per-transaction timer aborts a hung SD read.
module sd_read_arbiter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int RELEASE_CYCLES = 2
) (
    input logic              clk,
    input logic              rst,
    sd_read_arbiter_if.slave bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int RW = $clog2(RELEASE_CYCLES) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [RW-1:0] REL_LAST   = RW'(RELEASE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DELIVER,
        S_RELEASE
    } state_t;

    state_t        state_q,      state_d;
    logic          sd_req_q,     sd_req_d;
    logic [1:0]    grant_q,      grant_d;
    logic          valid0_q,     valid0_d;
    logic          valid1_q,     valid1_d;
    logic [7:0]    data0_q,      data0_d;
    logic [7:0]    data1_q,      data1_d;
    logic          tmo_q,        tmo_d;
    logic          err_src_q,    err_src_d;
    logic          last_grant_q, last_grant_d;
    logic [TW-1:0] timer_q,      timer_d;
    logic [RW-1:0] rel_cnt_q,    rel_cnt_d;

    // The owner index is implied by the one-hot grant while a transaction is live.
    logic winner;
    logic any_req;
    logic pick;

    assign winner  = grant_q[1];
    assign any_req = bus.req0_read_req | bus.req1_read_req;
    // On a tie the requester that did not win last time goes next.
    assign pick    = (bus.req0_read_req && bus.req1_read_req) ? ~last_grant_q
                                                               : bus.req1_read_req;

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d      = state_q;
        sd_req_d     = sd_req_q;
        grant_d      = grant_q;
        valid0_d     = 1'b0;
        valid1_d     = 1'b0;
        data0_d      = data0_q;
        data1_d      = data1_q;
        tmo_d        = 1'b0;
        err_src_d    = err_src_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        rel_cnt_d    = rel_cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d  = pick ? 2'b10 : 2'b01;
                    sd_req_d = 1'b1;
                    timer_d  = '0;
                    state_d  = S_WAIT;
                end
            end

            // Requests are not looked at here: withdrawal cannot cancel a read.
            S_WAIT: begin
                if (bus.sd_data_valid) begin
                    // A byte arriving on the last timer cycle still counts.
                    if (winner) begin
                        data1_d  = bus.sd_data;
                        valid1_d = 1'b1;
                    end else begin
                        data0_d  = bus.sd_data;
                        valid0_d = 1'b1;
                    end
                    sd_req_d = 1'b0;
                    state_d  = S_DELIVER;
                end else if (timer_q == TIMER_LAST) begin
                    sd_req_d  = 1'b0;
                    tmo_d     = 1'b1;
                    err_src_d = winner;
                    rel_cnt_d = '0;
                    state_d   = S_RELEASE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            // The valid pulse is visible during this state only.
            S_DELIVER: begin
                rel_cnt_d = '0;
                state_d   = S_RELEASE;
            end

            // Grant is held and requests ignored, so a requester that drops its
            // request a few cycles late is not granted a second time.
            S_RELEASE: begin
                if (rel_cnt_q == REL_LAST) begin
                    last_grant_d = winner;
                    grant_d      = 2'b00;
                    state_d      = S_IDLE;
                end else begin
                    rel_cnt_d = rel_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before this edge.
        if (!rst) begin
            state_q      <= S_IDLE;
            sd_req_q     <= 1'b0;
            grant_q      <= 2'b00;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            data0_q      <= 8'h00;
            data1_q      <= 8'h00;
            tmo_q        <= 1'b0;
            err_src_q    <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            rel_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            sd_req_q     <= sd_req_d;
            grant_q      <= grant_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
            tmo_q        <= tmo_d;
            err_src_q    <= err_src_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            rel_cnt_q    <= rel_cnt_d;
        end
    end

    assign bus.sd_read_req = sd_req_q;
    assign bus.grant       = grant_q;
    assign bus.req0_valid  = valid0_q;
    assign bus.req1_valid  = valid1_q;
    assign bus.req0_data   = data0_q;
    assign bus.req1_data   = data1_q;
    assign bus.timeout_err = tmo_q;
    assign bus.err_src     = err_src_q;

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Scoreboard bench for sd_read_arbiter: stimulus pushes expected deliveries and
// aborts into queues, a monitor pops and compares whenever the DUT reports one.
module tb_sd_read_arbiter;

    localparam int TMO = 16;
    localparam int REL = 2;

    logic clk;
    logic rst;
    logic rst_q;

    sd_read_arbiter_if bus ();

    sd_read_arbiter #(
        .TIMEOUT_CYCLES(TMO),
        .RELEASE_CYCLES(REL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       idx;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic err_q[$];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] last0;
    logic [7:0] last1;
    logic       last_err;
    exp_t       e;
    logic       e_src;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) rst_q <= rst;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_sd_req();
        int n = 0;
        while (bus.sd_read_req !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("sd_req_seen", 32'(bus.sd_read_req), 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.grant !== 2'b00 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_reached", 32'(bus.grant), 0);
    endtask

    // SD model: once a read is pending, wait 'delay' cycles then return one byte.
    task automatic respond(input logic [7:0] d, input int delay);
        wait_sd_req();
        repeat (delay) begin
            @(posedge clk); #1;
        end
        bus.sd_data_valid = 1'b1;
        bus.sd_data       = d;
        @(posedge clk); #1;
        bus.sd_data_valid = 1'b0;
        bus.sd_data       = 8'h00;
    endtask

    // Monitor: compares every delivery/abort against the scoreboard and checks
    // hold behaviour and invariants each cycle.
    always @(posedge clk) begin
        #1;
        if (rst_q !== 1'b1) begin
            check("reset_outputs",
                  {9'd0, bus.grant, bus.sd_read_req, bus.req0_valid, bus.req1_valid,
                   bus.req0_data, bus.req1_data, bus.timeout_err, bus.err_src}, 0);
            last0    = 8'h00;
            last1    = 8'h00;
            last_err = 1'b0;
        end else begin
            check("invariants",
                  {29'd0, (bus.grant == 2'b11), (bus.req0_valid & bus.req1_valid),
                   (bus.sd_read_req & (bus.grant == 2'b00))}, 0);
            if (bus.req0_valid || bus.req1_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_delivery", {30'd0, bus.req1_valid, bus.req0_valid}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("delivery_owner", {30'd0, bus.req1_valid, bus.req0_valid},
                          e.idx ? 32'd2 : 32'd1);
                    check("delivery_data", e.idx ? 32'(bus.req1_data) : 32'(bus.req0_data),
                          32'(e.data));
                    if (e.idx) last1 = e.data;
                    else       last0 = e.data;
                end
            end
            check("req0_data_hold", 32'(bus.req0_data), 32'(last0));
            check("req1_data_hold", 32'(bus.req1_data), 32'(last1));
            if (bus.timeout_err) begin
                if (err_q.size() == 0) begin
                    check("unexpected_timeout", 32'(bus.timeout_err), 0);
                end else begin
                    e_src = err_q.pop_front();
                    check("abort_err_src", 32'(bus.err_src), 32'(e_src));
                    last_err = e_src;
                end
            end
            check("err_src_hold", 32'(bus.err_src), 32'(last_err));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        rst               = 1'b0;
        bus.req0_read_req = 1'b1;
        bus.req1_read_req = 1'b1;
        bus.sd_data_valid = 1'b0;
        bus.sd_data       = 8'h00;

        // Reset held with both requests high; req0 wins the first tie.
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("reset_grant", 32'(bus.grant), 0);
        check("reset_sd_req", 32'(bus.sd_read_req), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("first_grant", {30'd0, bus.grant}, 32'h1);
        check("first_sd_req", 32'(bus.sd_read_req), 1);

        // Contention: strict alternation 0,1,0,1.
        exp_q.push_back('{1'b0, 8'h11});
        exp_q.push_back('{1'b1, 8'h22});
        exp_q.push_back('{1'b0, 8'h33});
        exp_q.push_back('{1'b1, 8'h44});
        respond(8'h11, 1);
        respond(8'h22, 0);
        respond(8'h33, 4);
        respond(8'h44, 2);
        bus.req0_read_req = 1'b0;
        bus.req1_read_req = 1'b0;
        wait_idle();

        // Single req0: 1-cycle request latency, DELIVER + RELEASE_CYCLES hold.
        bus.req0_read_req = 1'b1;
        @(posedge clk); #1;
        check("req_latency_sd_req", 32'(bus.sd_read_req), 1);
        check("req_latency_grant", 32'(bus.grant), 32'h1);
        exp_q.push_back('{1'b0, 8'hA5});
        respond(8'hA5, 3);
        check("single_valid", {30'd0, bus.req1_valid, bus.req0_valid}, 32'h1);
        bus.req0_read_req = 1'b0;
        for (int i = 0; i < REL; i++) begin
            @(posedge clk); #1;
            check("release_grant_held", 32'(bus.grant), 32'h1);
        end
        @(posedge clk); #1;
        check("release_grant_drop", 32'(bus.grant), 0);

        // Timeout on req1, then a late byte that must be ignored.
        bus.req1_read_req = 1'b1;
        err_q.push_back(1'b1);
        wait_sd_req();
        check("tmo_grant", 32'(bus.grant), 32'h2);
        for (int i = 1; i < TMO; i++) begin
            @(posedge clk); #1;
            check("tmo_wait", {30'd0, bus.timeout_err, bus.sd_read_req}, 32'h1);
        end
        @(posedge clk); #1;
        check("tmo_pulse", {29'd0, bus.timeout_err, bus.sd_read_req, bus.err_src}, 32'h5);
        bus.sd_data_valid = 1'b1;
        bus.sd_data       = 8'h77;
        @(posedge clk); #1;
        bus.sd_data_valid = 1'b0;
        bus.sd_data       = 8'h00;
        check("tmo_one_cycle", 32'(bus.timeout_err), 0);
        bus.req1_read_req = 1'b0;
        wait_idle();

        // Valid arriving on the final timer cycle beats the timeout.
        bus.req0_read_req = 1'b1;
        exp_q.push_back('{1'b0, 8'h5C});
        respond(8'h5C, TMO - 1);
        check("edge_valid_wins", {30'd0, bus.timeout_err, bus.req0_valid}, 32'h1);
        bus.req0_read_req = 1'b0;
        wait_idle();

        // Reset during WAIT aborts silently; req0 regranted afterwards.
        bus.req1_read_req = 1'b1;
        wait_sd_req();
        check("pre_reset_grant", 32'(bus.grant), 32'h2);
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.req0_read_req = 1'b1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_reset_outputs",
              {27'd0, bus.sd_read_req, bus.grant, bus.req0_valid, bus.req1_valid},
              0);
        check("mid_reset_err", 32'(bus.timeout_err), 0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("regrant_req0", {30'd0, bus.grant}, 32'h1);
        exp_q.push_back('{1'b0, 8'h3C});
        respond(8'h3C, 0);
        bus.req0_read_req = 1'b0;
        bus.req1_read_req = 1'b0;
        wait_idle();

        repeat (3) begin
            @(posedge clk); #1;
        end
        check("deliveries_drained", exp_q.size(), 0);
        check("aborts_drained", err_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
